checkout_sequencer: RTL

CHECKOUT_SEQUENCER -- requirements
Module: checkout_sequencer

---
 rtl/checkout_pkg.sv | 34 +++
 rtl/shift_add_mul.sv | 70 +++++++
 rtl/checkout_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/checkout_pkg.sv
// Shared definitions for the checkout sequencer: command/error encodings,
// FSM states, arithmetic limits and default widths.
package checkout_pkg;

    localparam int PRICE_W_DEF = 14;
    localparam int TOTAL_W_DEF = 17;
    localparam int QTY_W_DEF   = 7;

    localparam int QTY_MAX   = 99;
    localparam int TOTAL_MAX = 99999;

    typedef enum logic [1:0] {
        OP_ITEM  = 2'b00,
        OP_QTY   = 2'b01,
        OP_SHOW  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COMMIT = 3'd1,
        MUL    = 3'd2,
        CHECK  = 3'd3,
        REPORT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_QTY_RANGE = 2'b01,
        ERR_PROD_OVF  = 2'b10,
        ERR_TOTAL_OVF = 2'b11
    } err_code_e;

endpackage

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, B_W cycles
// after start; done_o marks the final iteration cycle, product_o holds afterwards.
module shift_add_mul #(
    parameter int A_W = 17,
    parameter int B_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic             done_o,
    output logic [A_W+B_W-1:0] product_o
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(B_W + 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P_W-1:0]   mcand_q, mcand_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic [B_W-1:0]   mplier_q, mplier_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = CNT_W'(B_W - 1);
            mcand_d  = P_W'(a_i);
            acc_d    = '0;
            mplier_d = b_i;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    assign done_o    = busy_q && (cnt_q == '0);
    assign product_o = acc_q;

endmodule

// File: rtl/checkout_sequencer.sv
// Checkout register controller: accumulates item prices into a running total,
// applies quantity multipliers to the pending item, and reports on a display.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// COMMIT | fold pending into total, then load/clear pending
// MUL    | shift-add multiplication of pending by quantity
// CHECK  | range-check product and update pending
// REPORT | publish total or pending to the display
module checkout_sequencer
    import checkout_pkg::*;
#(
    parameter int PRICE_W = PRICE_W_DEF,
    parameter int TOTAL_W = TOTAL_W_DEF,
    parameter int QTY_W   = QTY_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [PRICE_W-1:0] cmd_data,
    output logic [TOTAL_W-1:0] disp_value,
    output logic               disp_valid,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int PROD_W = TOTAL_W + QTY_W;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [PRICE_W-1:0] data_q, data_d;
    logic               show_pend_q, show_pend_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [TOTAL_W-1:0] pending_q, pending_d;
    logic [TOTAL_W-1:0] disp_q, disp_d;
    logic               disp_valid_q, disp_valid_d;
    logic               err_q, err_d;
    err_code_e          err_code_q, err_code_d;

    op_e                op_in;
    logic               accept;
    logic               qty_in_range;
    logic               mul_start;
    logic               mul_done;
    logic [PROD_W-1:0]  product;
    logic [TOTAL_W:0]   sum;
    logic               sum_ovf;
    logic               prod_ovf;

    assign op_in        = op_e'(cmd_op);
    assign accept       = cmd_valid && (state_q == IDLE);
    assign qty_in_range = (cmd_data <= PRICE_W'(QTY_MAX));
    assign sum          = {1'b0, total_q} + {1'b0, pending_q};
    assign sum_ovf      = (sum > (TOTAL_W+1)'(TOTAL_MAX));
    assign prod_ovf     = (product > PROD_W'(TOTAL_MAX));

    // Pending can already be a multiplied amount, so the multiplicand is the
    // full pending width rather than a single price.
    shift_add_mul #(
        .A_W (TOTAL_W),
        .B_W (QTY_W)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (pending_q),
        .b_i       (cmd_data[QTY_W-1:0]),
        .done_o    (mul_done),
        .product_o (product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_in == OP_CLEAR || err_q) begin
                        state_d = REPORT;
                    end else if (op_in == OP_QTY) begin
                        state_d = qty_in_range ? MUL : REPORT;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT:  state_d = REPORT;
            MUL:     if (mul_done) state_d = CHECK;
            CHECK:   state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        mul_start = accept && (op_in == OP_QTY) && !err_q && qty_in_range;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= OP_ITEM;
            data_q       <= '0;
            show_pend_q  <= 1'b0;
            total_q      <= '0;
            pending_q    <= '0;
            disp_q       <= '0;
            disp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            op_q         <= op_d;
            data_q       <= data_d;
            show_pend_q  <= show_pend_d;
            total_q      <= total_d;
            pending_q    <= pending_d;
            disp_q       <= disp_d;
            disp_valid_q <= disp_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    always_comb begin
        op_d         = op_q;
        data_d       = data_q;
        show_pend_d  = show_pend_q;
        total_d      = total_q;
        pending_d    = pending_q;
        disp_d       = disp_q;
        disp_valid_d = 1'b0;
        err_d        = err_q;
        err_code_d   = err_code_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d        = op_in;
                    data_d      = cmd_data;
                    show_pend_d = 1'b0;
                    if (op_in == OP_CLEAR) begin
                        total_d    = '0;
                        pending_d  = '0;
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                    end else if (!err_q && op_in == OP_QTY) begin
                        show_pend_d = 1'b1;
                        if (!qty_in_range) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_QTY_RANGE;
                        end
                    end
                end
            end
            COMMIT: begin
                if (sum_ovf) begin
                    err_d      = 1'b1;
                    err_code_d = err_q ? err_code_q : ERR_TOTAL_OVF;
                end else begin
                    total_d = sum[TOTAL_W-1:0];
                end
                pending_d = (op_q == OP_ITEM) ? TOTAL_W'(data_q) : '0;
            end
            CHECK: begin
                if (prod_ovf) begin
                    err_d      = 1'b1;
                    err_code_d = err_q ? err_code_q : ERR_PROD_OVF;
                end else begin
                    pending_d = product[TOTAL_W-1:0];
                end
            end
            REPORT: begin
                disp_d       = show_pend_q ? pending_q : total_q;
                disp_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign disp_value = disp_q;
    assign disp_valid = disp_valid_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule
